// File: rtl/mm_arb_pkg.sv
// Shared widths, state encoding and defaults for the two-requester
// matrix-memory arbiter.
package mm_arb_pkg;

    localparam int ADDR_W        = 20;
    localparam int RD_W          = 20;
    localparam int WR_W          = 40;
    localparam int MAX_BURST_DEF = 16;
    // Wide enough to hold MAX_BURST up to 255 when the counter saturates.
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mm_arb_rr.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// whoever did not own the port most recently.
module mm_arb_rr (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       pick
);

    // Pick requester index from the request vector and the previous owner.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_owner;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/mm_mem_arb.sv
// Arbiter sharing one matrix-memory port between two requesters. Ownership
// is held per burst (bounded by MAX_BURST unless the owner locks), memory
// signals are muxed combinationally from the owner, and reads return one
// cycle later on a shared rd_data bus tagged to the requester that issued it.
//
//   state | meaning
//   IDLE  | nobody owns the port, memory strobes held low
//   OWN0  | requester 0 drives the memory port
//   OWN1  | requester 1 drives the memory port
module mm_mem_arb
    import mm_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_i,
    input  logic [ADDR_W-1:0] r0_j,
    input  logic              r0_index,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [WR_W-1:0]   r0_write_data,
    output logic              r0_gnt,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_i,
    input  logic [ADDR_W-1:0] r1_j,
    input  logic              r1_index,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [WR_W-1:0]   r1_write_data,
    output logic              r1_gnt,
    output logic              r1_rvalid,

    output logic [RD_W-1:0]   rd_data,

    output logic [ADDR_W-1:0] mem_i,
    output logic [ADDR_W-1:0] mem_j,
    output logic              mem_index,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WR_W-1:0]   mem_write_data,
    input  logic [RD_W-1:0]   mem_read_data
);

    // Owned-cycle count before the current cycle; the burst ends once this
    // cycle brings the total to MAX_BURST.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] BURST_SAT  = CNT_W'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_owner_q, last_owner_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic [RD_W-1:0]  rd_data_q, rd_data_d;

    logic             rr_pick;
    logic             burst_done;

    mm_arb_rr u_rr (
        .req        ({r1_req, r0_req}),
        .last_owner (last_owner_q),
        .pick       (rr_pick)
    );

    assign burst_done = (cnt_q >= BURST_LAST);

    // State register plus burst counter, owner history and read return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Next ownership, burst count and last-owner bookkeeping.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    state_d = rr_pick ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN0: begin
                if (!r0_req) begin
                    state_d = r1_req ? ST_OWN1 : ST_IDLE;
                end else if (r1_req && burst_done && !r0_lock) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!r1_req) begin
                    state_d = r0_req ? ST_OWN0 : ST_IDLE;
                end else if (r0_req && burst_done && !r1_lock) begin
                    state_d = ST_OWN0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Locked owners keep counting up to MAX_BURST and then hold there.
        if ((state_d != state_q) || (state_d == ST_IDLE)) begin
            cnt_d = '0;
        end else if (cnt_q != BURST_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_d != state_q) begin
            if (state_d == ST_OWN0) begin
                last_owner_d = 1'b0;
            end else if (state_d == ST_OWN1) begin
                last_owner_d = 1'b1;
            end
        end
    end

    // Owner mux onto the memory port, grants, and read-return capture.
    always_comb begin
        mem_i          = '0;
        mem_j          = '0;
        mem_index      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;

        case (state_q)
            ST_OWN0: begin
                mem_i          = r0_i;
                mem_j          = r0_j;
                mem_index      = r0_index;
                mem_write_data = r0_write_data;
                mem_write      = r0_req & r0_write;
                // A simultaneous write takes the cycle; the read is dropped.
                mem_read       = r0_req & r0_read & ~r0_write;
            end
            ST_OWN1: begin
                mem_i          = r1_i;
                mem_j          = r1_j;
                mem_index      = r1_index;
                mem_write_data = r1_write_data;
                mem_write      = r1_req & r1_write;
                mem_read       = r1_req & r1_read & ~r1_write;
            end
            default: ;
        endcase

        r0_gnt    = (state_q == ST_OWN0);
        r1_gnt    = (state_q == ST_OWN1);

        // Tag is taken from the issuing cycle so a switch cannot misroute it.
        rvalid0_d = mem_read & (state_q == ST_OWN0);
        rvalid1_d = mem_read & (state_q == ST_OWN1);
        rd_data_d = mem_read ? mem_read_data : rd_data_q;
    end

    assign r0_rvalid = rvalid0_q;
    assign r1_rvalid = rvalid1_q;
    assign rd_data   = rd_data_q;

endmodule

// File: doc/mm_mem_arb.md
MM_MEM_ARB -- requirements
Module: mm_mem_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning max consecutive owned cycles before yielding to a waiting requester (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports rN_req  input  1  requester N (N=0,1) wants the matrix memory port.
REQ-005 SHALL have ports rN_lock  input  1  requester N asks to keep ownership past MAX_BURST.
REQ-006 SHALL have ports rN_i, rN_j  input  20 each  requester N row/column address.
REQ-007 SHALL have ports rN_index  input  1  requester N matrix select (0=A/C, 1=B).
REQ-008 SHALL have ports rN_read, rN_write  input  1 each  requester N access strobes.
REQ-009 SHALL have ports rN_write_data  input  40  requester N write value.
REQ-010 SHALL have ports rN_gnt  output  1  requester N owns the port this cycle.
REQ-011 SHALL have ports rN_rvalid  output  1  read data for requester N valid this cycle.
REQ-012 SHALL have port rd_data  output  20  registered read return, shared by both requesters.
REQ-013 SHALL have ports mem_i, mem_j  output  20 each; mem_index, mem_read, mem_write  output  1 each; mem_write_data  output  40; mem_read_data  input  20.

Function
REQ-014 SHALL implement states IDLE, OWN0, OWN1; rN_gnt = (state==OWNN), registered.
REQ-015 IDLE: one req -> OWN of that requester next cycle; both -> requester not in last_owner register; none -> stay IDLE.
REQ-016 OWNN: rN_req low -> OWN of other if its req high, else IDLE (no dead cycle on switch).
REQ-017 OWNN: burst counter counts owned cycles; counter reaching MAX_BURST with other req high and rN_lock low -> switch to other; with lock high -> stay, counter saturates.
REQ-018 Counter SHALL clear to 0 on every ownership change and in IDLE; last_owner updates on each entry into OWNN.
REQ-019 Memory outputs SHALL be combinationally muxed from the owner; in IDLE mem_read=mem_write=0, address/data outputs 0.
REQ-020 mem_read/mem_write SHALL be gated by the owner's rN_req; a non-owner's strobes SHALL never reach memory.
REQ-021 Owner read and write both high: write passes, read suppressed, no rvalid.
REQ-022 Read latency 1: rd_data <= mem_read_data and rN_rvalid pulses the cycle after an issued read, tagged to the issuing owner even if ownership switched.
REQ-023 A write SHALL complete in the issuing cycle; no response signal.

Reset
REQ-024 reset high SHALL asynchronously force state=IDLE, last_owner=1 (so r0 wins first tie), counter=0, rd_data=0, all gnt/rvalid=0.
REQ-025 Reset mid-burst SHALL drop grant immediately; a read issued the cycle before SHALL not produce rvalid.

Structure
REQ-026 Package mm_arb_pkg SHALL hold the state encoding (2-bit), ADDR_W=20, RD_W=20, WR_W=40, default MAX_BURST.
REQ-027 Round-robin pick SHALL be one sub-module mm_arb_rr (inputs req[1:0], last_owner; output pick); remainder flat.

Verification
REQ-028 Both req high from IDLE after reset -> r0_gnt next cycle, r1_gnt after r0 drops req.
REQ-029 r0 holds req, r1 waits, MAX_BURST=4, lock=0 -> r0_gnt exactly 4 cycles, r1_gnt on the 5th cycle with no gap.
REQ-030 Same as REQ-029 with r0_lock=1 -> r0 keeps grant 20 cycles until req drops, then r1_gnt next cycle.
REQ-031 r1 owns, reads i=3 j=5 index=1, memory returns 20'hFFFFE -> mem outputs match same cycle; rd_data=20'hFFFFE, r1_rvalid=1 next cycle, r0_rvalid=0.
REQ-032 Non-owner r1 asserts write with 40'h12345 while r0 owns -> mem_write reflects r0 only, no r1 write.
REQ-033 Assert reset during OWN0 cycle 2 with a read pending -> gnt, rvalid, rd_data 0 immediately; after release, single r1 req -> r1_gnt next cycle.
